// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU issue/retire stage: opcodes, the canonical NaN,
// the buffered request record and the issue FSM states.
package fpu_pkg;

    localparam logic [6:0]  FPU_OP_ADD    = 7'd1;
    localparam logic [6:0]  FPU_OP_SUB    = 7'd2;
    localparam logic [6:0]  FPU_OP_MUL    = 7'd3;
    localparam logic [31:0] FPU_QNAN      = 32'h7FC0_0000;

    // Tags narrower than this are zero-extended into the stored record.
    localparam int          FPU_TAG_MAX_W = 16;

    typedef struct packed {
        logic [31:0]              data1;
        logic [31:0]              data2;
        logic [6:0]               opcode;
        logic [FPU_TAG_MAX_W-1:0] tag;
    } fpu_req_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ISSUE = 2'd1,
        ST_STALL = 2'd2,
        ST_DRAIN = 2'd3
    } fpu_state_e;

    function automatic logic fpuIsLegalOp(input logic [6:0] op);
        return (op == FPU_OP_ADD) || (op == FPU_OP_SUB) || (op == FPU_OP_MUL);
    endfunction

endpackage

// File: rtl/fpu_req_fifo.sv
// Request FIFO for the FPU issue stage: DEPTH entries (power of two), wrapping
// pointers, occupancy count, head presented combinationally (all-zero when empty).
module fpu_req_fifo
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  fpu_req_t               i_pushReq,
    output fpu_req_t               o_headReq,
    output logic                   o_empty,
    output logic                   o_full,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fpu_req_t         r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == CNT_W'(DEPTH));
    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;

    assign o_headReq = o_empty ? '0 : r_mem[r_rdPtr];
    assign o_count   = r_count;

    // Storage needs no reset: an entry is only read once the count covers it.
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_pushReq;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fpu_issue_buffer.sv
// Issue/retire wrapper around the combinational FPU core: request FIFO, head issue,
// registered result slot with valid/ready. Optional macro: FPU_ILLEGAL_OP_CHECK_EN.
module fpu_issue_buffer
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_data1,
    input  logic [31:0]            in_data2,
    input  logic [6:0]             in_opcode,
    input  logic [TAG_W-1:0]       in_tag,
    output logic [31:0]            fpu_data1,
    output logic [31:0]            fpu_data2,
    output logic [6:0]             fpu_opcode,
    input  logic [31:0]            fpu_result,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_result,
    output logic [TAG_W-1:0]       out_tag,
    output logic                   out_illegal,
    output logic [$clog2(DEPTH):0] count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fpu_req_t         w_pushReq;
    fpu_req_t         w_headReq;
    logic             w_empty;
    logic             w_full;
    logic [CNT_W-1:0] w_count;
    logic             w_push;
    logic             w_pop;
    logic             w_slotFree;
    logic             w_lastPop;
    logic             w_headIllegal;
    logic [31:0]      w_capResult;
    logic             w_unusedTagBits;

    logic             r_outValid;
    logic [31:0]      r_outResult;
    logic [TAG_W-1:0] r_outTag;
    logic             r_outIllegal;

    fpu_state_e       r_state;
    fpu_state_e       w_nextState;

    assign w_pushReq.data1  = in_data1;
    assign w_pushReq.data2  = in_data2;
    assign w_pushReq.opcode = in_opcode;
    assign w_pushReq.tag    = FPU_TAG_MAX_W'(in_tag);

    // A full FIFO refuses pushes even when the head is leaving this cycle.
    assign in_ready   = !w_full;
    assign w_push     = in_valid && !w_full;
    assign w_slotFree = !r_outValid || out_ready;
    assign w_pop      = !w_empty && w_slotFree;
    assign w_lastPop  = w_pop && (w_count == CNT_W'(1));

    fpu_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_pushReq (w_pushReq),
        .o_headReq (w_headReq),
        .o_empty   (w_empty),
        .o_full    (w_full),
        .o_count   (w_count)
    );

    assign fpu_data1  = w_headReq.data1;
    assign fpu_data2  = w_headReq.data2;
    assign fpu_opcode = w_headReq.opcode;
    assign count      = w_count;

    // Tag bits above TAG_W are always zero; fold them into a sink.
    assign w_unusedTagBits = ^w_headReq.tag;

`ifdef FPU_ILLEGAL_OP_CHECK_EN
    assign w_headIllegal = !fpuIsLegalOp(w_headReq.opcode);
    assign w_capResult   = w_headIllegal ? FPU_QNAN : fpu_result;
`else
    assign w_headIllegal = 1'b0;
    assign w_capResult   = fpu_result;
`endif

    // Result slot: capture the head whenever the slot is free, else drain or hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_outValid   <= 1'b0;
            r_outResult  <= '0;
            r_outTag     <= '0;
            r_outIllegal <= 1'b0;
        end else if (w_pop) begin
            r_outValid   <= 1'b1;
            r_outResult  <= w_capResult;
            r_outTag     <= w_headReq.tag[TAG_W-1:0];
            r_outIllegal <= w_headIllegal;
        end else if (r_outValid && out_ready) begin
            r_outValid   <= 1'b0;
        end
    end

    assign out_valid   = r_outValid;
    assign out_result  = r_outResult;
    assign out_tag     = r_outTag;
    assign out_illegal = r_outIllegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Tracks issue progress; the slot itself drains from EMPTY or ISSUE.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_push) begin
                    w_nextState = (r_outValid && !out_ready) ? ST_STALL : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (r_outValid && !out_ready && !w_empty) begin
                    w_nextState = ST_STALL;
                end else if ((w_lastPop || w_empty) && !w_push) begin
                    w_nextState = ST_EMPTY;
                end
            end
            ST_STALL: begin
                if (out_ready) begin
                    w_nextState = ST_ISSUE;
                end
            end
            default: begin
                w_nextState = ST_EMPTY;
            end
        endcase
    end

endmodule

// File: tb/tb_fpu_issue_buffer.sv
// Self-checking bench for fpu_issue_buffer: behavioural FPU stand-in plus a
// scoreboard queue of expected results in issue order.
module tb_fpu_issue_buffer;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data1;
    logic [31:0]      in_data2;
    logic [6:0]       in_opcode;
    logic [TAG_W-1:0] in_tag;
    logic [31:0]      fpu_data1;
    logic [31:0]      fpu_data2;
    logic [6:0]       fpu_opcode;
    logic [31:0]      fpu_result;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;
    logic [2:0]       count;

    typedef struct {
        logic [31:0]      result;
        logic [TAG_W-1:0] tag;
        logic             illegal;
    } exp_t;

    exp_t sbQueue[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    fpu_issue_buffer #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data1    (in_data1),
        .in_data2    (in_data2),
        .in_opcode   (in_opcode),
        .in_tag      (in_tag),
        .fpu_data1   (fpu_data1),
        .fpu_data2   (fpu_data2),
        .fpu_opcode  (fpu_opcode),
        .fpu_result  (fpu_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_tag     (out_tag),
        .out_illegal (out_illegal),
        .count       (count)
    );

    // Stand-in for the FPU core: exact for 1.0 + 2.0, a cheap mixing function otherwise.
    function automatic logic [31:0] fakeFpu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [6:0] op);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000 && op == 7'd1) begin
            return 32'h4040_0000;
        end
        return (a ^ {b[15:0], b[31:16]}) + {25'd0, op};
    endfunction

    assign fpu_result = fakeFpu(fpu_data1, fpu_data2, fpu_opcode);

    function automatic exp_t makeExp(input logic [31:0] a, input logic [31:0] b,
                                     input logic [6:0] op, input logic [TAG_W-1:0] tag);
        exp_t e;
        e.tag = tag;
`ifdef FPU_ILLEGAL_OP_CHECK_EN
        if (op inside {7'd1, 7'd2, 7'd3}) begin
            e.result  = fakeFpu(a, b, op);
            e.illegal = 1'b0;
        end else begin
            e.result  = 32'h7FC0_0000;
            e.illegal = 1'b1;
        end
`else
        e.result  = fakeFpu(a, b, op);
        e.illegal = 1'b0;
`endif
        return e;
    endfunction

    // Scoreboard: handshakes are judged at the falling edge before the edge they fire on.
    always @(negedge clk) begin : scoreboard
        exp_t e;
        if (!rst) begin
            if (out_valid && out_ready) begin
                checks++;
                if (sbQueue.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL sb_unexpected: got tag=%0d result=%h, expected no output",
                             out_tag, out_result);
                end else begin
                    e = sbQueue.pop_front();
                    if (out_result !== e.result || out_tag !== e.tag || out_illegal !== e.illegal) begin
                        errors++;
                        $display("[TB] FAIL sb_result: got result=%h tag=%0d ill=%0b, expected result=%h tag=%0d ill=%0b",
                                 out_result, out_tag, out_illegal, e.result, e.tag, e.illegal);
                    end
                end
            end
            if (in_valid && in_ready) begin
                sbQueue.push_back(makeExp(in_data1, in_data2, in_opcode, in_tag));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b,
                                 input logic [6:0] op, input logic [TAG_W-1:0] tag);
        in_valid  = v;
        in_data1  = a;
        in_data2  = b;
        in_opcode = op;
        in_tag    = tag;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        out_ready = 1'b0;
        applyStimulus(1'b0, '0, '0, '0, '0);
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got valid=%0b count=%0d ready=%0b, expected 0 0 1",
                     out_valid, count, in_ready);
        end
        checks++;
        if (out_result !== 32'd0 || out_tag !== '0 || out_illegal !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_slot: got result=%h tag=%0d ill=%0b, expected all 0",
                     out_result, out_tag, out_illegal);
        end
        checks++;
        if (fpu_data1 !== 32'd0 || fpu_data2 !== 32'd0 || fpu_opcode !== 7'd0) begin
            errors++;
            $display("[TB] FAIL reset_fpu: got %h %h %0d, expected all 0", fpu_data1, fpu_data2, fpu_opcode);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_add();
        out_ready = 1'b1;
        applyStimulus(1'b1, 32'h3F80_0000, 32'h4000_0000, 7'd1, 4'd5);
        tick();
        applyStimulus(1'b0, '0, '0, '0, '0);
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd1 || fpu_data1 !== 32'h3F80_0000 || fpu_opcode !== 7'd1) begin
            errors++;
            $display("[TB] FAIL add_issue: got valid=%0b count=%0d fpu_a=%h op=%0d, expected 0 1 3f800000 1",
                     out_valid, count, fpu_data1, fpu_opcode);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'h4040_0000 || out_tag !== 4'd5 || count !== 3'd0) begin
            errors++;
            $display("[TB] FAIL add_result: got valid=%0b result=%h tag=%0d count=%0d, expected 1 40400000 5 0",
                     out_valid, out_result, out_tag, count);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL add_drain: got valid=%0b, expected 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        exp_t firstExp;
        logic [31:0] a;
        logic [31:0] b;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = $urandom;
            if (i == 0) begin
                firstExp = makeExp(a, b, 7'd1, 4'd1);
            end
            applyStimulus(1'b1, a, b, 7'((i % 3) + 1), 4'(i + 1));
            tick();
        end
        checks++;
        if (count !== 3'd3 || in_ready !== 1'b1 || out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_fill: got count=%0d ready=%0b valid=%0b, expected 3 1 1",
                     count, in_ready, out_valid);
        end
        applyStimulus(1'b1, $urandom, $urandom, 7'd3, 4'd5);
        tick();
        checks++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_full: got count=%0d ready=%0b, expected 4 0", count, in_ready);
        end
        applyStimulus(1'b1, $urandom, $urandom, 7'd2, 4'd6);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (count !== 3'd4 || in_ready !== 1'b0 || out_valid !== 1'b1 ||
                out_result !== firstExp.result || out_tag !== 4'd1) begin
                errors++;
                $display("[TB] FAIL bp_hold: got count=%0d ready=%0b valid=%0b result=%h tag=%0d, expected 4 0 1 %h 1",
                         count, in_ready, out_valid, out_result, out_tag, firstExp.result);
            end
        end
        applyStimulus(1'b0, '0, '0, '0, '0);
    endtask

    task automatic test_release();
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (count !== 3'(4 - k) || out_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL release_count: got count=%0d valid=%0b, expected %0d 1",
                         count, out_valid, 4 - k);
            end
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || sbQueue.size() != 0) begin
            errors++;
            $display("[TB] FAIL release_done: got valid=%0b pending=%0d, expected 0 0",
                     out_valid, sbQueue.size());
        end
    endtask

    task automatic test_back_to_back();
        int n;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, $urandom, $urandom, 7'((i % 3) + 1), 4'(7 + i));
            tick();
        end
        checks++;
        if (count !== 3'd2) begin
            errors++;
            $display("[TB] FAIL b2b_prefill: got count=%0d, expected 2", count);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, $urandom, $urandom, 7'((i % 3) + 1), 4'(10 + i));
            tick();
            checks++;
            if (count !== 3'd2 || out_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL b2b_steady: got count=%0d valid=%0b, expected 2 1", count, out_valid);
            end
        end
        applyStimulus(1'b0, '0, '0, '0, '0);
        n = 0;
        while ((count !== 3'd0 || out_valid !== 1'b0) && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || sbQueue.size() != 0) begin
            errors++;
            $display("[TB] FAIL b2b_drain: got count=%0d valid=%0b pending=%0d, expected 0 0 0",
                     count, out_valid, sbQueue.size());
        end
    endtask

    task automatic test_illegal();
        exp_t e;
        out_ready = 1'b1;
        e = makeExp(32'h1234_5678, 32'h9ABC_DEF0, 7'd9, 4'd9);
        applyStimulus(1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 7'd9, 4'd9);
        tick();
        applyStimulus(1'b0, '0, '0, '0, '0);
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_result !== e.result || out_illegal !== e.illegal) begin
            errors++;
            $display("[TB] FAIL illegal_op: got valid=%0b result=%h ill=%0b, expected 1 %h %0b",
                     out_valid, out_result, out_illegal, e.result, e.illegal);
        end
        tick();
        applyStimulus(1'b1, 32'h0000_00FF, 32'h0F0F_0000, 7'd3, 4'd3);
        tick();
        applyStimulus(1'b0, '0, '0, '0, '0);
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_illegal !== 1'b0) begin
            errors++;
            $display("[TB] FAIL legal_after_illegal: got valid=%0b ill=%0b, expected 1 0", out_valid, out_illegal);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, $urandom, $urandom, 7'd2, 4'(i));
            tick();
        end
        applyStimulus(1'b0, '0, '0, '0, '0);
        checks++;
        if (count !== 3'd3 || out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_prefill: got count=%0d valid=%0b, expected 3 1", count, out_valid);
        end
        rst = 1'b1;
        tick();
        sbQueue.delete();
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1 ||
            fpu_data1 !== 32'd0 || fpu_data2 !== 32'd0 || fpu_opcode !== 7'd0) begin
            errors++;
            $display("[TB] FAIL mid_reset: got valid=%0b count=%0d ready=%0b fpu=%h/%h/%0d, expected 0 0 1 0/0/0",
                     out_valid, count, in_ready, fpu_data1, fpu_data2, fpu_opcode);
        end
        rst       = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("[TB] FAIL post_reset: got valid=%0b count=%0d, expected 0 0", out_valid, count);
        end
    endtask

    initial begin
        $display("[TB] starting fpu_issue_buffer bench");
        test_reset();
        test_single_add();
        test_backpressure();
        test_release();
        test_back_to_back();
        test_illegal();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpu_issue_buffer.md
# fpu_issue_buffer

Sequential issue/retire stage wrapped around the combinational single-precision FPU core (add/sub/mult). Buffers incoming operation requests in a small FIFO and drives the FIFO head onto the FPU operand/opcode lines. Captures the FPU result into a registered output slot with valid/ready handshake and tag, so the pipeline tolerates back-pressure from the consumer.

## Interface
Parameters:
- DEPTH, 4 — request FIFO entries; power of two, ≥2
- TAG_W, 4 — width of the request tag carried to the result

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  request present
- in_ready  out  1  FIFO can accept (= !full)
- in_data1  in  32  operand A (IEEE-754 single)
- in_data2  in  32  operand B
- in_opcode  in  7  1 = add, 2 = sub, 3 = mult; others illegal
- in_tag  in  TAG_W  request tag
- fpu_data1  out  32  operand A to FPU core
- fpu_data2  out  32  operand B to FPU core
- fpu_opcode  out  7  opcode to FPU core
- fpu_result  in  32  combinational result from FPU core
- out_valid  out  1  result slot full
- out_ready  in  1  consumer accepts result
- out_result  out  32  captured result
- out_tag  out  TAG_W  tag of captured result
- out_illegal  out  1  result came from an illegal opcode (tied 0 without macro)
- count  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Push: in_valid && in_ready at edge → entry {data1, data2, opcode, tag} written at wr_ptr; wr_ptr wraps modulo DEPTH.
- in_ready = (count != DEPTH); no same-cycle pass-through when full, even if a pop occurs.
- fpu_* driven combinationally from FIFO head; all-zero when FIFO empty.
- Output slot free = !out_valid || out_ready.
- Pop/capture: FIFO non-empty && slot free at edge → out_result ← fpu_result, out_tag ← head tag, out_valid ← 1, rd_ptr advances.
- Drain without refill: out_valid && out_ready && (FIFO empty) → out_valid ← 0.
- Simultaneous push and pop: count unchanged; both pointers advance.
- FSM (2 bits): EMPTY (count 0, slot empty) → ISSUE on push; ISSUE (head present, slot free) captures each cycle; ISSUE → STALL when out_valid && !out_ready with head present; STALL → ISSUE when out_ready; ISSUE → EMPTY when last entry captured and no push; DRAIN state not used (slot drain handled in EMPTY/ISSUE).
- Sub is handled by the FPU core; this block passes opcode unchanged.

## Timing
- Reset: count 0, pointers 0, FSM EMPTY, out_valid 0, out_result 0, out_tag 0, out_illegal 0, in_ready 1, fpu_* 0.
- Reset mid-operation: all buffered requests and the pending result discarded; no output on the following cycle.
- Latency: request pushed at edge N → out_valid high from edge N+1 if slot free (FPU evaluated in cycle between N and N+1).
- Throughput: one result per cycle while out_ready held high.
- out_result/out_tag/out_illegal stable while out_valid && !out_ready.

## Configuration
- FPU_ILLEGAL_OP_CHECK_EN defined: opcode ∉ {1,2,3} → captured out_result = 32'h7FC00000 (canonical quiet NaN), out_illegal = 1; FPU result ignored.
- Undefined: no check; fpu_result captured as-is for every opcode; out_illegal constant 0.

## Structure
- Package fpu_pkg: opcode constants (FPU_OP_ADD=7'd1, FPU_OP_SUB=7'd2, FPU_OP_MUL=7'd3), QNAN constant, request struct {data1, data2, opcode, tag}, FSM state enum.
- One sub-module: fpu_req_fifo (storage, pointers, count); FSM and result slot in top.

## Test plan
- Single add 0x3F800000 + 0x40000000 tag 5, out_ready=1 → out_valid one cycle after push, out_result 0x40400000, out_tag 5.
- Push 4 requests with out_ready=0 → after 1st captured, count reaches 3; 5th push: in_ready=1 until count=4, then 0; result held stable.
- Release out_ready with FIFO full → results emitted in tag order, one per cycle, count decrements to 0, pointers wrap.
- Push and pop same cycle at count=2 → count stays 2, no lost or duplicated tags.
- Opcode 7'd9 with macro defined → out_result 0x7FC00000, out_illegal=1; without macro out_illegal=0.
- Assert rst with 3 entries and out_valid=1 → next cycle out_valid=0, count=0, in_ready=1, fpu_* 0.
